// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-facing signals of the 8-to-1 mux scan sequencer.
// The master modport is the side that requests scans and supplies Y.
interface mux_sel_sequencer_if;
  logic       start;
  logic [7:0] data_in;
  logic       y_in;
  logic [7:0] i_out;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] captured;
  logic       err;

  modport master (
    output start, data_in, y_in,
    input  i_out, sel, busy, done, captured, err
  );

  modport slave (
    input  start, data_in, y_in,
    output i_out, sel, busy, done, captured, err
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Drives a pattern onto an 8-to-1 mux, steps its select 0..7 (DIV clocks
// per code), captures Y at the end of each step and flags mismatches.
//
// state   | meaning
// IDLE    | waiting for start; captured/err hold the last scan result
// STEP    | pattern applied, select stepping, Y sampled on divider wrap
// DONE    | single-cycle done pulse, start ignored
module mux_sel_sequencer #(
  parameter int unsigned DIV = 4
) (
  input logic                clk,
  input logic                rst,
  mux_sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] i_out_q, i_out_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] captured_q, captured_d;
  logic       err_q, err_d;
  logic [7:0] div_q, div_d;
  logic       step_end;

  assign step_end = (state_q == ST_STEP) && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      i_out_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      err_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      i_out_q    <= i_out_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_STEP;
      ST_STEP: if (step_end && (sel_q == 3'd7)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shadow_d   = shadow_q;
    i_out_d    = i_out_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    captured_d = captured_q;
    err_d      = err_q;
    div_d      = div_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shadow_d   = bus.data_in;
          i_out_d    = bus.data_in;
          sel_d      = '0;
          captured_d = '0;
          err_d      = 1'b0;
          div_d      = '0;
          busy_d     = 1'b1;
        end
      end
      ST_STEP: begin
        if (step_end) begin
          captured_d[sel_q] = bus.y_in;
          // compare against the shadow so data_in changes mid-scan cannot leak in
          if (bus.y_in != shadow_q[sel_q]) err_d = 1'b1;
          if (sel_q == 3'd7) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            sel_d = sel_q + 3'd1;
            div_d = '0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.i_out    = i_out_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.captured = captured_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: behavioural mux on Y, a scoreboard of expected
// scan results, and two builds (DIV=4 and DIV=1) sharing clock and reset.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  logic       fault = 1'b0;
  logic       use1 = 1'b0;
  logic [7:0] din = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] cap;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_sel_sequencer_if b4();
  mux_sel_sequencer_if b1();

  assign b4.start   = start4;
  assign b4.data_in = din;
  assign b4.y_in    = fault ? 1'b0 : b4.i_out[b4.sel];
  assign b1.start   = start1;
  assign b1.data_in = din;
  assign b1.y_in    = fault ? 1'b0 : b1.i_out[b1.sel];

  mux_sel_sequencer #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_sel_sequencer #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // {busy, done, sel, i_out, err, captured}
  logic [21:0] all4, all1, m_all;
  assign all4  = {b4.busy, b4.done, b4.sel, b4.i_out, b4.err, b4.captured};
  assign all1  = {b1.busy, b1.done, b1.sel, b1.i_out, b1.err, b1.captured};
  assign m_all = use1 ? all1 : all4;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int div, input logic v);
    if (div == 1) start1 = v;
    else          start4 = v;
  endtask

  // Runs one scan; expected results come from the pattern and the fault mode.
  task automatic run_scan(input int div, input logic [7:0] data, input bit flt,
                          input bit disturb, input bit hold_end);
    exp_t        e;
    logic [7:0]  cap_m;
    logic        err_m;
    logic [21:0] exp_v;
    int          steps;
    use1  = (div == 1);
    fault = flt;
    e.cap = flt ? 8'h00 : data;
    e.err = flt && (data != 8'h00);
    sb.push_back(e);
    din = data;
    set_start(div, 1'b1);
    tick();
    set_start(div, 1'b0);
    for (int n = 0; n < 8 * div; n++) begin
      steps = n / div;
      cap_m = 8'h00;
      err_m = 1'b0;
      for (int j = 0; j < steps; j++) begin
        cap_m[j] = flt ? 1'b0 : data[j];
        if (cap_m[j] != data[j]) err_m = 1'b1;
      end
      exp_v = {1'b1, 1'b0, 3'(steps), data, err_m, cap_m};
      checks++;
      if (m_all !== exp_v) begin
        errors++;
        $display("FAIL scan_step div=%0d n=%0d: got %h expected %h", div, n, m_all, exp_v);
      end
      if (disturb && n == 5) begin
        set_start(div, 1'b1);
        din = 8'h00;
      end
      if (disturb && n == 6) set_start(div, 1'b0);
      if (hold_end && n == 8 * div - 1) set_start(div, 1'b1);
      tick();
    end
    checks++;
    if (m_all[21:20] !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse div=%0d: got busy,done=%b expected 01", div, m_all[21:20]);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({m_all[7:0], m_all[8]} !== {e.cap, e.err}) begin
        errors++;
        $display("FAIL scan_result data=%h: got cap=%h err=%b expected cap=%h err=%b",
                 data, m_all[7:0], m_all[8], e.cap, e.err);
      end
    end
    tick();
    checks++;
    if ({m_all[21:20], m_all[7:0], m_all[8]} !== {2'b00, e.cap, e.err}) begin
      errors++;
      $display("FAIL idle_hold data=%h: got busy,done=%b cap=%h err=%b expected 00 %h %b",
               data, m_all[21:20], m_all[7:0], m_all[8], e.cap, e.err);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all4 !== 22'd0) begin
      errors++;
      $display("FAIL reset_div4: got %h expected 0", all4);
    end
    checks++;
    if (all1 !== 22'd0) begin
      errors++;
      $display("FAIL reset_div1: got %h expected 0", all1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal;
    run_scan(4, 8'hAD, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_faulty;
    run_scan(4, 8'hAD, 1'b1, 1'b0, 1'b0);
    fault = 1'b0;
  endtask

  task automatic test_ignore;
    run_scan(4, 8'hAD, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (b4.done !== 1'b0 || b4.busy !== 1'b0) begin
        errors++;
        $display("FAIL extra_done k=%0d: got busy,done=%b%b expected 00", k, b4.busy, b4.done);
      end
      tick();
    end
  endtask

  task automatic test_start_through_done;
    run_scan(4, 8'h96, 1'b0, 1'b0, 1'b1);
    run_scan(4, 8'h3C, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    use1 = 1'b0;
    din  = 8'hAD;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (12) tick();
    checks++;
    if (b4.sel !== 3'd3) begin
      errors++;
      $display("FAIL mid_run_sel: got %0d expected 3", b4.sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all4 !== 22'd0) begin
      errors++;
      $display("FAIL mid_run_reset: got %h expected 0", all4);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (all4 !== 22'd0) begin
        errors++;
        $display("FAIL reset_hold k=%0d: got %h expected 0", k, all4);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_scan(4, 8'h5A, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_div1;
    run_scan(1, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_scan(1, 8'hAD, 1'b1, 1'b0, 1'b0);
    fault = 1'b0;
    use1  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_faulty();
    test_ignore();
    test_start_through_done();
    test_reset_mid_run();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream driver and checker for the 8-to-1 mux stage. On a start request it latches an 8-bit pattern onto the mux data inputs I0..I7, then steps the mux select S2..S0 through 0..7, holding each code for DIV clocks. It samples the mux output Y at the end of each step, assembles the captured byte, flags any mismatch against the expected bit, and pulses done. Used as the self-checking harness and stimulus front-end for the mux on the lab board.

Parameters:
DIV, 4, clocks each select code is held; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request a scan; sampled only in IDLE
data_in  input  8  pattern to apply; bit i drives I_i
y_in  input  1  mux output Y (combinational from i_out/sel)
i_out  output  8  registered drive to mux I7..I0
sel  output  3  registered select; sel[2]=S2, sel[1]=S1, sel[0]=S0
busy  output  1  high while scanning
done  output  1  one-cycle pulse at scan completion
captured  output  8  captured[k] = y_in sampled while sel=k
err  output  1  sticky mismatch flag for the current or last scan

Behaviour:
- Reset (async, immediate, any state): state=IDLE; i_out=0, sel=0, busy=0, done=0, captured=0, err=0, step counter=0.
- States: IDLE, STEP, DONE.
- IDLE: start=1 on an edge -> STEP. On that same edge: shadow=data_in, i_out=data_in, sel=0, captured=0, err=0, divider=0, busy=1.
- STEP: the divider counts 0..DIV-1. On the edge where divider=DIV-1:
  - captured[sel] <= y_in.
  - If y_in != shadow[sel], err <= 1.
  - If sel=7: -> DONE, busy=0, done=1. sel and i_out hold their values.
  - Otherwise: sel <= sel+1 and divider <= 0.
- DONE: lasts exactly one cycle, then -> IDLE with done=0. Start is ignored in DONE.
- Timing: start sampled at edge t0. Select code k is visible for cycles t0+1+k*DIV .. t0+(k+1)*DIV. done is high during cycle t0+8*DIV+1. Busy time is 8*DIV cycles.
- start while busy or in DONE: ignored, no effect on the run.
- data_in changes during a scan: ignored; i_out and the compare use shadow.
- captured and err hold their values from DONE until the next accepted start.
- DIV=1: sel advances every cycle, and y_in is sampled in the same cycle sel is applied.
- sel never wraps within a scan; 7 -> DONE, never 7 -> 0.
- Divider width is 8 bits; no overflow is possible within the legal DIV range.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs read 0 immediately; state IDLE.
- Normal scan: DIV=4, behavioural mux model, data_in=8'hAD (I0=1,I1=0,I2=1,I3=1,I4=0,I5=1,I6=0,I7=1), start pulse -> sel steps 0..7 with 4 cycles each; captured=8'hAD; err=0; done high exactly 33 cycles after the start edge; busy high for 32 cycles.
- Faulty mux: Y stuck at 0, data_in=8'hAD -> captured=8'h00, err=1 after the sel=0 step, err stays 1 through done and into IDLE.
- Ignore rules: during a scan, pulse start and change data_in to 8'h00 -> i_out stays 8'hAD, captured=8'hAD, only one done pulse. Start held high through the DONE cycle -> not accepted until IDLE; the next scan begins the following edge.
- Reset mid-run: with sel=3, assert rst -> all outputs 0, no done pulse. Then start with data_in=8'h5A -> captured=8'h5A, err=0.
- DIV=1 build: data_in=8'hFF -> sel changes every cycle, done 9 cycles after start, captured=8'hFF.
